// File: rtl/rst_sequencer.sv
// Board-level reset scheduler: qualifies PLL lock, debounces the reset button and
// releases the debug, peripheral and core reset domains in order.
module rst_sequencer #(
    parameter int DebounceCycles   = 50000,
    parameter int LockStableCycles = 256,
    parameter int StageGapCycles   = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       rst_btn_i,
    input  logic       soft_rst_req_i,
    output logic       rst_dbg_no,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic       seq_done_o,
    output logic [1:0] rst_cause_o
);
    localparam int DbW = $clog2(DebounceCycles + 1);
    localparam int LkW = $clog2(LockStableCycles + 1);
    localparam int GpW = $clog2(StageGapCycles + 1);

    localparam logic [DbW-1:0] DbMax = DbW'(DebounceCycles);
    localparam logic [LkW-1:0] LkMax = LkW'(LockStableCycles);
    localparam logic [GpW-1:0] GpMax = GpW'(StageGapCycles);

    localparam logic [1:0] CausePor  = 2'b00;
    localparam logic [1:0] CauseBtn  = 2'b01;
    localparam logic [1:0] CausePll  = 2'b10;
    localparam logic [1:0] CauseSoft = 2'b11;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STAGE_PERIPH,
        STAGE_CORE,
        RUN,
        BTN_HOLD,
        SOFT_HOLD
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     lock_sync_q, lock_sync_d;
    logic [1:0]     btn_sync_q, btn_sync_d;
    logic           btn_deb_q, btn_deb_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d, db_inc;
    logic [LkW-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
    logic [GpW-1:0] gap_cnt_q, gap_cnt_d, gap_inc;
    logic [1:0]     cause_q, cause_d;
    logic           dbg_q, dbg_d;
    logic           periph_q, periph_d;
    logic           core_q, core_d;
    logic           done_q, done_d;
    logic           lock_s;
    logic           btn_s;

    always_comb begin
        lock_sync_d = {lock_sync_q[0], pll_locked_i};
        btn_sync_d  = {btn_sync_q[0], rst_btn_i};
        lock_s      = lock_sync_q[1];
        btn_s       = btn_sync_q[1];

        // Counters saturate at their terminal value instead of wrapping.
        db_inc   = (db_cnt_q == DbMax) ? db_cnt_q : db_cnt_q + DbW'(1);
        lock_inc = (lock_cnt_q == LkMax) ? lock_cnt_q : lock_cnt_q + LkW'(1);
        gap_inc  = (gap_cnt_q == GpMax) ? gap_cnt_q : gap_cnt_q + GpW'(1);

        btn_deb_d = btn_deb_q;
        db_cnt_d  = '0;
        if (btn_s != btn_deb_q) begin
            if (db_inc == DbMax) begin
                btn_deb_d = btn_s;
            end else begin
                db_cnt_d = db_inc;
            end
        end

        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            WAIT_LOCK:    if (lock_s && lock_inc == LkMax) state_d = STAGE_PERIPH;
            STAGE_PERIPH: if (gap_inc == GpMax) state_d = STAGE_CORE;
            STAGE_CORE:   if (gap_inc == GpMax) state_d = RUN;
            RUN: begin
                if (soft_rst_req_i) begin
                    state_d = SOFT_HOLD;
                    cause_d = CauseSoft;
                end
            end
            BTN_HOLD:     if (!btn_deb_q) state_d = WAIT_LOCK;
            SOFT_HOLD:    if (gap_inc == GpMax) state_d = STAGE_PERIPH;
            default:      state_d = WAIT_LOCK;
        endcase

        // Later assignments win, so lock loss outranks the button.
        if (btn_deb_q && state_q != BTN_HOLD) begin
            state_d = BTN_HOLD;
            cause_d = CauseBtn;
        end
        if (!lock_s && state_q != WAIT_LOCK) begin
            state_d = WAIT_LOCK;
            cause_d = CausePll;
        end

        lock_cnt_d = (state_q == WAIT_LOCK && lock_s) ? lock_inc : '0;
        gap_cnt_d  = '0;
        if (state_d == state_q &&
            (state_q inside {STAGE_PERIPH, STAGE_CORE, SOFT_HOLD})) begin
            gap_cnt_d = gap_inc;
        end

        // Outputs are registered from the next state so they track state_q exactly.
        dbg_d    = state_d inside {STAGE_PERIPH, STAGE_CORE, RUN, SOFT_HOLD};
        periph_d = state_d inside {STAGE_CORE, RUN};
        core_d   = (state_d == RUN);
        done_d   = (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= WAIT_LOCK;
            lock_sync_q <= '0;
            btn_sync_q  <= '0;
            btn_deb_q   <= 1'b0;
            db_cnt_q    <= '0;
            lock_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            cause_q     <= CausePor;
            dbg_q       <= 1'b0;
            periph_q    <= 1'b0;
            core_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_sync_q <= lock_sync_d;
            btn_sync_q  <= btn_sync_d;
            btn_deb_q   <= btn_deb_d;
            db_cnt_q    <= db_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            cause_q     <= cause_d;
            dbg_q       <= dbg_d;
            periph_q    <= periph_d;
            core_q      <= core_d;
            done_q      <= done_d;
        end
    end

    assign rst_dbg_no    = dbg_q;
    assign rst_periph_no = periph_q;
    assign rst_core_no   = core_q;
    assign seq_done_o    = done_q;
    assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: timed expectations are queued as stimulus is
// applied and compared against {dbg, periph, core, done, cause} when they fall due.
module tb_rst_sequencer;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       pll_locked;
    logic       rst_btn;
    logic       soft_req;
    logic       rst_dbg_n;
    logic       rst_periph_n;
    logic       rst_core_n;
    logic       seq_done;
    logic [1:0] rst_cause;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         due_q[$];
    logic [5:0] val_q[$];
    string      tag_q[$];

    rst_sequencer #(
        .DebounceCycles  (4),
        .LockStableCycles(8),
        .StageGapCycles  (3)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .pll_locked_i  (pll_locked),
        .rst_btn_i     (rst_btn),
        .soft_rst_req_i(soft_req),
        .rst_dbg_no    (rst_dbg_n),
        .rst_periph_no (rst_periph_n),
        .rst_core_no   (rst_core_n),
        .seq_done_o    (seq_done),
        .rst_cause_o   (rst_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int due, input logic [5:0] val, input string tag);
        due_q.push_back(due);
        val_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    // Full release: dbg at base, periph 3 later, core and done 3 after that.
    task automatic expect_seq(input int base, input logic [1:0] cause, input string tag);
        expect_at(base - 1, {4'b0000, cause}, {tag, "_held"});
        expect_at(base,     {4'b1000, cause}, {tag, "_dbg"});
        expect_at(base + 2, {4'b1000, cause}, {tag, "_periph_held"});
        expect_at(base + 3, {4'b1100, cause}, {tag, "_periph"});
        expect_at(base + 5, {4'b1100, cause}, {tag, "_core_held"});
        expect_at(base + 6, {4'b1111, cause}, {tag, "_run"});
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [5:0] obs;
        #1;
        obs = {rst_dbg_n, rst_periph_n, rst_core_n, seq_done, rst_cause};
        for (int i = due_q.size() - 1; i >= 0; i--) begin
            if (due_q[i] <= cyc) begin
                checks++;
                assert (due_q[i] == cyc && obs === val_q[i]) else begin
                    errors++;
                    $error("FAIL %s: cycle %0d observed %b expected %b (due %0d)",
                           tag_q[i], cyc, obs, val_q[i], due_q[i]);
                end
                due_q.delete(i);
                val_q.delete(i);
                tag_q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int h;
        int p;
        int s;
        int b;
        int r;

        rst_ni     = 1'b0;
        pll_locked = 1'b1;
        rst_btn    = 1'b0;
        soft_req   = 1'b0;

        // Power-on
        expect_at(2, 6'b000000, "reset_state");
        expect_at(5, 6'b000000, "reset_hold");
        tick_to(5);
        rst_ni = 1'b1;
        base = cyc + 10;
        expect_seq(base, 2'b00, "por");
        tick_to(base + 8);

        // Button bounce in RUN must not disturb anything
        h = cyc;
        for (int k = 1; k <= 20; k++) expect_at(h + k, 6'b111100, "bounce");
        for (int i = 0; i < 6; i++) begin
            rst_btn = (i % 2 == 0);
            tick_to(cyc + 2);
        end
        rst_btn = 1'b0;
        tick_to(h + 21);

        // Button held: resets drop after 2+4+1, sequence repeats on release
        h = cyc;
        rst_btn = 1'b1;
        expect_at(h + 6, 6'b111100, "btn_pre");
        expect_at(h + 7, 6'b000001, "btn_assert");
        expect_at(h + 9, 6'b000001, "btn_hold");
        tick_to(h + 10);
        rst_btn = 1'b0;
        expect_seq(h + 25, 2'b01, "btn_seq");
        tick_to(h + 33);

        // PLL loss in RUN
        p = cyc;
        pll_locked = 1'b0;
        expect_at(p + 2, 6'b111101, "pll_pre");
        expect_at(p + 3, 6'b000010, "pll_loss");
        expect_at(p + 5, 6'b000010, "pll_wait");
        tick_to(p + 6);
        pll_locked = 1'b1;
        expect_seq(p + 16, 2'b10, "pll_seq");
        tick_to(p + 24);

        // Soft reset in RUN, then a soft request in STAGE_CORE is dropped
        s = cyc;
        soft_req = 1'b1;
        expect_at(s,      6'b111110, "soft_pre");
        expect_at(s + 1,  6'b100011, "soft_hold");
        expect_at(s + 3,  6'b100011, "soft_hold_end");
        expect_at(s + 4,  6'b100011, "soft_stage_periph");
        expect_at(s + 6,  6'b100011, "soft_periph_held");
        expect_at(s + 7,  6'b110011, "soft_periph");
        expect_at(s + 9,  6'b110011, "soft_core_held");
        expect_at(s + 10, 6'b111111, "soft_run");
        tick_to(s + 1);
        soft_req = 1'b0;
        tick_to(s + 8);
        soft_req = 1'b1;
        tick_to(s + 9);
        soft_req = 1'b0;
        expect_at(s + 11, 6'b111111, "soft_ignored");
        expect_at(s + 14, 6'b111111, "soft_not_queued");
        tick_to(s + 16);

        // Lock loss on the same edge the debounced button rises
        h = cyc;
        rst_btn = 1'b1;
        expect_at(h + 6, 6'b111111, "sim_pre");
        expect_at(h + 7, 6'b000010, "sim_pll_wins");
        expect_at(h + 8, 6'b000001, "sim_btn_next");
        expect_at(h + 9, 6'b000001, "sim_btn_hold");
        tick_to(h + 4);
        pll_locked = 1'b0;
        tick_to(h + 5);
        pll_locked = 1'b1;
        tick_to(h + 10);
        rst_btn = 1'b0;

        // rst_ni mid-sequence, then a lock glitch during qualification
        b = h + 25;
        expect_at(b - 1, 6'b000001, "mid_held");
        expect_at(b,     6'b100001, "mid_dbg");
        expect_at(b + 1, 6'b100001, "mid_stage");
        expect_at(b + 2, 6'b000000, "mid_rst");
        tick_to(b + 1);
        rst_ni = 1'b0;
        tick_to(b + 2);
        rst_ni = 1'b1;
        r = cyc;
        tick_to(r + 7);
        pll_locked = 1'b0;
        tick_to(r + 8);
        pll_locked = 1'b1;
        expect_at(r + 10, 6'b000000, "glitch_no_early");
        expect_seq(r + 18, 2'b00, "glitch_seq");
        tick_to(r + 26);

        for (int k = 0; k < 50 && due_q.size() > 0; k++) @(negedge clk);
        if (due_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never reached, required 0", due_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Board-level reset scheduler. Qualifies PLL lock, debounces the user reset button and accepts a software reset request.
- Releases three reset domains in a fixed order: debug (JTAG TAP/DM), then peripherals, then the Ibex core.
- Sits in the FPGA top between the clock generator and the demo system, clocked by the buffered board clock.
- Records the cause of the last reset for software.

Parameters:
- DebounceCycles, 50000: consecutive stable cycles before a button level change is accepted.
- LockStableCycles, 256: consecutive cycles of synchronised PLL lock required before sequencing starts.
- StageGapCycles, 16: cycles between successive domain releases; also the soft-reset hold time.

Ports:
- clk_i  input  1  single clock for the block.
- rst_ni  input  1  synchronous, active-low reset.
- pll_locked_i  input  1  raw PLL lock, asynchronous.
- rst_btn_i  input  1  raw reset button, active-high, asynchronous, bouncy.
- soft_rst_req_i  input  1  single-cycle software reset request, synchronous to clk_i.
- rst_dbg_no  output  1  debug-domain reset, active-low.
- rst_periph_no  output  1  peripheral-domain reset, active-low.
- rst_core_no  output  1  core-domain reset, active-low.
- seq_done_o  output  1  high while all domains are released (RUN).
- rst_cause_o  output  2  last cause: 00 power-on, 01 button, 10 PLL loss, 11 soft.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset rst_ni is synchronous and active-low, sampled on the clk_i rising edge.
  - While rst_ni is low: all reset outputs 0, seq_done_o 0, rst_cause_o 00, state WAIT_LOCK, all counters 0, debounced button 0, synchroniser flops 0.
- Synchronisers:
  - Two-flop synchronisers on pll_locked_i and rst_btn_i; 2-cycle latency.
  - No synchroniser on soft_rst_req_i.
- Debounce:
  - A counter increments while the synchronised button differs from the debounced level; it clears to 0 when they match.
  - When the counter reaches DebounceCycles, the debounced level flips and the counter clears.
- Counter width: each counter is $clog2(param+1) bits and saturates; it never wraps.
- All outputs are registered. Every transition below takes effect on the edge that makes its condition true, and the outputs reflect the new state in the following cycle.
- States:
  - WAIT_LOCK:
    - All three resets asserted.
    - The lock counter counts consecutive cycles with synchronised lock high and clears on any low.
    - At count == LockStableCycles: release rst_dbg_no, go to STAGE_PERIPH with the gap counter cleared.
  - STAGE_PERIPH:
    - After StageGapCycles cycles: release rst_periph_no, go to STAGE_CORE.
  - STAGE_CORE:
    - After StageGapCycles cycles: release rst_core_no, assert seq_done_o in the same cycle, go to RUN.
  - RUN:
    - Steady state; all resets released.
  - BTN_HOLD:
    - All resets asserted.
    - Stays until the debounced button returns to 0, then goes to WAIT_LOCK.
  - SOFT_HOLD:
    - rst_periph_no and rst_core_no asserted; rst_dbg_no stays released.
    - After StageGapCycles cycles: go to STAGE_PERIPH.
- Abort conditions (priority highest first, evaluated every cycle):
  1. Synchronised lock low in any state other than WAIT_LOCK: all resets asserted next cycle, seq_done_o 0, cause 10, go to WAIT_LOCK.
  2. Debounced button 1 in any state other than BTN_HOLD: all resets asserted, cause 01, go to BTN_HOLD.
  3. soft_rst_req_i in RUN only: cause 11, go to SOFT_HOLD.
- Soft requests in any state other than RUN are dropped, not queued.
- A lock loss while in BTN_HOLD goes to WAIT_LOCK with cause 10; the debounced button remaining high then re-enters BTN_HOLD.
- rst_cause_o persists until the next reset event. A rst_ni assertion mid-sequence returns everything to reset values within one cycle.
- Invariant: rst_core_no=1 implies rst_periph_no=1, and rst_periph_no=1 implies rst_dbg_no=1 (except SOFT_HOLD, where only rst_dbg_no is released).

Test Plan:
All scenarios use DebounceCycles=4, LockStableCycles=8, StageGapCycles=3.
- Power-on: rst_ni low for 5 cycles, then high with pll_locked_i=1 throughout. Expect rst_dbg_no high 10 cycles (2 synchroniser + 8 lock) after rst_ni rises, rst_periph_no 3 cycles later, rst_core_no and seq_done_o 3 cycles after that, rst_cause_o=00.
- Lock glitch during qualification: pll_locked_i low for 1 cycle at lock count 5. Expect the lock counter to restart and rst_dbg_no to release 8 cycles after lock returns (plus synchroniser latency).
- Button bounce:
  - In RUN, toggle rst_btn_i every 2 cycles for 12 cycles, then hold it at 0. Expect no reset asserted and rst_cause_o unchanged.
  - Then hold rst_btn_i high for 10 cycles. Expect all resets low within 2+4+1 cycles and rst_cause_o=01.
  - After release, expect the full release sequence to repeat.
- PLL loss in RUN: drop pll_locked_i. Expect all resets and seq_done_o low 3 cycles later and rst_cause_o=10. On lock return, expect the full 8+3+3 sequence.
- Soft reset:
  - Pulse soft_rst_req_i in RUN. Expect rst_periph_no and rst_core_no low, rst_dbg_no held high, rst_cause_o=11, periph released after 3+3 cycles, core after 3 more.
  - Pulse soft_rst_req_i during STAGE_CORE. Expect it ignored.
- Simultaneous events: pll_locked_i drops in the same cycle the debounced button goes high. Expect rst_cause_o=10 and state WAIT_LOCK; with the button still high, expect BTN_HOLD next cycle and cause 01.
